// File: rtl/card_select_ctrl.sv
// Memory-card game controller: cursor movement, two-pick selection, timed reveal,
// pair matching and win detection for the 6x6 board.
//
// state     | meaning
// ST_FIRST  | waiting for the first pick
// ST_SECOND | first pick held, waiting for the second pick
// ST_SHOW   | both picks visible while the show timer runs down
// ST_WIN    | all pairs found, buttons ignored until reset
module card_select_ctrl #(
   parameter int SHOW_CYCLES = 50_000_000,
   parameter int PAIRS       = 18
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        btnUp,
   input  logic        btnDown,
   input  logic        btnLeft,
   input  logic        btnRight,
   input  logic        btnSelect,
   input  logic [4:0]  faceData,
   output logic [5:0]  faceAddr,
   output logic [5:0]  mem6x6,
   output logic [5:0]  selectedCard,
   output logic [5:0]  card1,
   output logic [5:0]  card2,
   output logic [35:0] matched,
   output logic [4:0]  pairsFound,
   output logic        win
);

   localparam int              CNT_W     = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [4:0]      PAIRS_MAX = 5'(PAIRS);
   localparam logic [5:0]      NO_CARD   = 6'h3F;

   typedef enum logic [1:0] {ST_FIRST, ST_SECOND, ST_SHOW, ST_WIN} state_t;

   state_t            state, state_nxt;
   logic [2:0]        row, row_nxt, col, col_nxt;
   logic [5:0]        mem_nxt, sel_nxt, card1_nxt, card2_nxt;
   logic [4:0]        face1, face1_nxt, pairs_nxt, pairs_inc;
   logic              hit, hit_nxt, win_nxt;
   logic [35:0]       matched_nxt;
   logic [CNT_W-1:0]  show_cnt, show_cnt_nxt;
   logic              cur_matched, can_move;

   assign faceAddr    = mem6x6;
   assign cur_matched = matched[mem6x6];

   always_comb begin
      state_nxt    = state;
      row_nxt      = row;
      col_nxt      = col;
      sel_nxt      = selectedCard;
      card1_nxt    = card1;
      card2_nxt    = card2;
      face1_nxt    = face1;
      hit_nxt      = hit;
      matched_nxt  = matched;
      pairs_nxt    = pairsFound;
      show_cnt_nxt = show_cnt;
      pairs_inc    = (pairsFound == PAIRS_MAX) ? pairsFound : pairsFound + 5'd1;
      can_move     = (state == ST_FIRST) || (state == ST_SECOND);

      case (state)
         ST_FIRST: begin
            if (btnSelect && !cur_matched) begin
               card1_nxt = mem6x6;
               sel_nxt   = mem6x6;
               face1_nxt = faceData;
               state_nxt = ST_SECOND;
            end
         end
         ST_SECOND: begin
            if (btnSelect && !cur_matched && (mem6x6 != card1)) begin
               card2_nxt    = mem6x6;
               sel_nxt      = mem6x6;
               hit_nxt      = (faceData == face1);
               show_cnt_nxt = SHOW_LOAD;
               state_nxt    = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (show_cnt == '0) begin
               if (hit) begin
                  matched_nxt[card1] = 1'b1;
                  matched_nxt[card2] = 1'b1;
                  pairs_nxt          = pairs_inc;
               end
               card1_nxt = NO_CARD;
               card2_nxt = NO_CARD;
               sel_nxt   = NO_CARD;
               state_nxt = (hit && (pairs_inc == PAIRS_MAX)) ? ST_WIN : ST_FIRST;
            end else begin
               show_cnt_nxt = show_cnt - 1'b1;
            end
         end
         ST_WIN: begin
         end
         default: state_nxt = ST_FIRST;
      endcase

      // A select pulse consumes the cycle even when the pick itself is refused.
      if (can_move && !btnSelect) begin
         if (btnUp)
            row_nxt = (row == 3'd0) ? 3'd5 : row - 3'd1;
         else if (btnDown)
            row_nxt = (row == 3'd5) ? 3'd0 : row + 3'd1;
         else if (btnLeft)
            col_nxt = (col == 3'd0) ? 3'd5 : col - 3'd1;
         else if (btnRight)
            col_nxt = (col == 3'd5) ? 3'd0 : col + 3'd1;
      end

      mem_nxt = ({3'b000, row_nxt} * 6'd6) + {3'b000, col_nxt};
      win_nxt = (state_nxt == ST_WIN);
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state        <= ST_FIRST;
         row          <= 3'd0;
         col          <= 3'd0;
         mem6x6       <= 6'd0;
         selectedCard <= NO_CARD;
         card1        <= NO_CARD;
         card2        <= NO_CARD;
         face1        <= 5'd0;
         hit          <= 1'b0;
         matched      <= 36'd0;
         pairsFound   <= 5'd0;
         show_cnt     <= '0;
         win          <= 1'b0;
      end else begin
         state        <= state_nxt;
         row          <= row_nxt;
         col          <= col_nxt;
         mem6x6       <= mem_nxt;
         selectedCard <= sel_nxt;
         card1        <= card1_nxt;
         card2        <= card2_nxt;
         face1        <= face1_nxt;
         hit          <= hit_nxt;
         matched      <= matched_nxt;
         pairsFound   <= pairs_nxt;
         show_cnt     <= show_cnt_nxt;
         win          <= win_nxt;
      end
   end

endmodule

// File: doc/card_select_ctrl.md
# card_select_ctrl

Game controller for the 6x6 memory-card board. It turns debounced single-cycle button pulses into the cursor, selection and pick indices that drive the LED grid (`mem6x6`, `selectedCard`, `card1`, `card2`). It also tracks matched pairs and detects the win condition. It sits between the button debouncers and the LED grid driver, and reads card faces from a combinational deck ROM.

## Interface
Parameters:
- `SHOW_CYCLES`, default 50_000_000: cycles both picks stay visible before they are resolved.
- `PAIRS`, default 18: number of pairs needed to win.

Ports:
- `clock`  in  1: system clock, rising edge.
- `resetN`  in  1: one clock; reset is asynchronous and active-low.
- `btnUp`, `btnDown`, `btnLeft`, `btnRight`, `btnSelect`  in  1 each: debounced pulses, each one cycle wide.
- `faceData`  in  5: face value of the cell at `faceAddr`, valid in the same cycle (combinational ROM).
- `faceAddr`  out  6: always equal to `mem6x6`.
- `mem6x6`  out  6: cursor index, computed as row*6+col.
- `selectedCard`  out  6: most recent accepted pick; 6'h3F when there is none.
- `card1`, `card2`  out  6: first and second pick; 6'h3F when empty.
- `matched`  out  36: one bit per cell that has been matched.
- `pairsFound`  out  5: count of matched pairs.
- `win`  out  1: high once `pairsFound` equals `PAIRS`.

## Operation
- State machine: FIRST (waiting for first pick) -> SECOND (waiting for second pick) -> SHOW (holding both picks) -> back to FIRST, or to WIN.
- The cursor is held as a row register and a column register, each 0..5.
  - Up/down: row -/+1, wrapping 0<->5.
  - Left/right: col -/+1, wrapping 0<->5.
  - The cursor never leaves its row or column through wrap.
- Only one button is honoured per cycle. Priority: select > up > down > left > right.
- FIRST, select pressed:
  - Ignored if `matched[mem6x6]` is set.
  - Otherwise `card1` and `selectedCard` take `mem6x6`, `faceData` is latched into `face1`, and the state moves to SECOND.
- SECOND, select pressed:
  - Ignored if the cursor cell is matched, or if it equals `card1`.
  - Otherwise `card2` and `selectedCard` take `mem6x6`.
  - `hit` is registered as (`faceData` == `face1`).
  - The show counter loads `SHOW_CYCLES-1`, and the state moves to SHOW.
- SHOW:
  - All buttons are ignored and the cursor is frozen.
  - The counter decrements once per cycle.
  - When the counter reaches 0, the block resolves:
    - If `hit`: set `matched[card1]` and `matched[card2]`, and increment `pairsFound`.
    - In both cases, `card1`, `card2` and `selectedCard` return to 6'h3F.
    - The next state is WIN if the incremented `pairsFound` equals `PAIRS`, otherwise FIRST.
- WIN:
  - `win`=1 and all buttons are ignored.
  - Only `resetN` leaves this state.
- Movement is allowed in FIRST and SECOND.
- `pairsFound` saturates at `PAIRS` and never wraps.

## Timing
- All outputs are registered except `faceAddr`.
- Reset values:
  - `mem6x6`=0 (row 0, col 0).
  - `card1`, `card2`, `selectedCard` = 6'h3F.
  - `matched`=0, `pairsFound`=0, `win`=0.
  - State is FIRST and the show counter is 0.
- A button pulse sampled at rising edge N is visible on the outputs after edge N: one cycle of latency.
- The face compare uses `faceData` for the cursor cell in the same cycle as the select pulse. No extra ROM cycle is needed.
- SHOW lasts exactly `SHOW_CYCLES` cycles from the edge that accepted the second pick. The resolution results appear on the edge that ends SHOW.
- Reset asserted mid-SHOW or in WIN: all registers clear immediately, asynchronously. On deassertion the block resumes in FIRST.
- Select together with a direction in the same cycle: select acts and the direction is dropped. The cursor does not move that cycle.

## Test plan
- Reset, then press right 7 times -> `mem6x6` steps 1,2,3,4,5,0,1. Then press up once -> `mem6x6`=31 (row 5, col 1).
- Cursor at 0 with face 3, select. Move to 1 with face 3, select. Use `SHOW_CYCLES`=4.
  - Required: `card1`=0 and `card2`=1 held for 4 cycles.
  - Then `matched[0]`=`matched[1]`=1, `pairsFound`=1, and all picks return to 6'h3F.
- Pick cells 0 and 2 with faces 3 and 7 -> after SHOW, `matched` is unchanged, `pairsFound` is unchanged, and picks return to 6'h3F.
- In SECOND with `card1`=5, select on cell 5 -> ignored: `card2` stays 6'h3F and the state stays SECOND. Selecting an already-matched cell in FIRST -> ignored.
- `PAIRS`=2: match two pairs -> `win`=1 on the resolving edge. Later button pulses change nothing. Pulsing `resetN` low mid-sequence clears every output to its reset value.
- Pulse `btnSelect` and `btnLeft` in the same cycle at cursor 0 -> `card1`=0 and `mem6x6` stays 0.
